// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - request/data/flag bundle between sync_fifo_flags and its users
interface sync_fifo_flags_if #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic                 flush;
  logic                 wr_en;
  logic [DATAWIDTH-1:0] wr_data;
  logic                 rd_en;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CNTW-1:0]      data_cnt;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, data_cnt, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, data_cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO, any depth, standard/FWFT read, thresholds, flush
// Sticky overflow/underflow registers are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_flags #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter bit FWFT      = 1'b0,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input logic              clk,
  input logic              resetn,
  sync_fifo_flags_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]      wptr_q, wptr_d;
  logic [PTRW-1:0]      rptr_q, rptr_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 full, empty;
  logic                 wr_acc, rd_acc;

  assign full   = (cnt_q == CNTW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign wr_acc = bus.wr_en & ~full & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      // explicit wrap so non-power-of-two depths never index past the array
      if (wr_acc) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTRW'(1);
      if (rd_acc) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTRW'(1);
      if (wr_acc && !rd_acc)      cnt_d = cnt_q + CNTW'(1);
      else if (rd_acc && !wr_acc) cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.wr_data;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt_q >= CNTW'(AF_LEVEL));
  assign bus.almost_empty = (cnt_q <= CNTW'(AE_LEVEL));
  assign bus.data_cnt     = cnt_q;

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data = empty ? '0 : mem_q[rptr_q];
    end else begin : g_std
      logic [DATAWIDTH-1:0] rd_data_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem_q[rptr_q];
      end
      assign bus.rd_data = rd_data_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow_q  <= 1'b1;
      if (bus.rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - queue-model checked bench, DEPTH=5 standard (A) and FWFT (B) FIFOs
module tb_sync_fifo_flags;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = 4;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) ifa ();
  sync_fifo_flags_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) ifb ();

  assign ifa.flush = flush;  assign ifa.wr_en = wr_en;  assign ifa.wr_data = wr_data;  assign ifa.rd_en = rd_en;
  assign ifb.flush = flush;  assign ifb.wr_en = wr_en;  assign ifb.wr_data = wr_data;  assign ifb.rd_en = rd_en;

  sync_fifo_flags #(.DATAWIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0), .AF_LEVEL(4), .AE_LEVEL(1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa.slave));
  sync_fifo_flags #(.DATAWIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb.slave));

  logic [DW-1:0] o_rd[2];
  logic [CW-1:0] o_cnt[2];
  logic          o_full[2], o_empty[2], o_af[2], o_ae[2], o_ovf[2], o_unf[2];
  assign o_rd[0] = ifa.rd_data;       assign o_rd[1] = ifb.rd_data;
  assign o_cnt[0] = ifa.data_cnt;     assign o_cnt[1] = ifb.data_cnt;
  assign o_full[0] = ifa.full;        assign o_full[1] = ifb.full;
  assign o_empty[0] = ifa.empty;      assign o_empty[1] = ifb.empty;
  assign o_af[0] = ifa.almost_full;   assign o_af[1] = ifb.almost_full;
  assign o_ae[0] = ifa.almost_empty;  assign o_ae[1] = ifb.almost_empty;
  assign o_ovf[0] = ifa.overflow;     assign o_ovf[1] = ifb.overflow;
  assign o_unf[0] = ifa.underflow;    assign o_unf[1] = ifb.underflow;

  function automatic int af_of(int k);
    return (k == 0) ? 4 : DEPTH - 2;
  endfunction

  function automatic int ae_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Model: instance contents as a queue; A keeps its last popped word, B shows the head
  logic [DW-1:0] mq[2][$];
  logic [DW-1:0] m_rd[2] = '{8'h00, 8'h00};
  bit            m_ovf[2] = '{1'b0, 1'b0};
  bit            m_unf[2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        mq[k].delete();
        m_rd[k]  = '0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end else if (flush) begin
        mq[k].delete();
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end else begin
        automatic bit was_full  = (mq[k].size() == DEPTH);
        automatic bit was_empty = (mq[k].size() == 0);
        automatic logic [DW-1:0] head;
        if (ERR && wr_en && was_full)  m_ovf[k] = 1'b1;
        if (ERR && rd_en && was_empty) m_unf[k] = 1'b1;
        if (rd_en && !was_empty) begin
          head = mq[k].pop_front();
          if (k == 0) m_rd[k] = head;
        end
        if (wr_en && !was_full) mq[k].push_back(wr_data);
      end
    end
  end

  function automatic int exp_rd(int k);
    if (k == 0) return int'(m_rd[0]);
    return (mq[1].size() != 0) ? int'(mq[1][0]) : 0;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int n = mq[k].size();
      chk("data_cnt", k, int'(o_cnt[k]), n);
      chk("full", k, int'(o_full[k]), int'(n == DEPTH));
      chk("empty", k, int'(o_empty[k]), int'(n == 0));
      chk("almost_full", k, int'(o_af[k]), int'(n >= af_of(k)));
      chk("almost_empty", k, int'(o_ae[k]), int'(n <= ae_of(k)));
      chk("overflow", k, int'(o_ovf[k]), int'(m_ovf[k]));
      chk("underflow", k, int'(o_unf[k]), int'(m_unf[k]));
      chk("rd_data", k, int'(o_rd[k]), exp_rd(k));
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("lit_reset_cnt", 0, int'(o_cnt[0]), 0);
    chk("lit_reset_empty", 0, int'(o_empty[0]), 1);
    chk("lit_reset_full", 0, int'(o_full[0]), 0);
    chk("lit_reset_ae", 0, int'(o_ae[0]), 1);
    chk("lit_reset_af", 0, int'(o_af[0]), 0);
    chk("lit_reset_rd", 0, int'(o_rd[0]), 0);
    chk("lit_reset_rd", 1, int'(o_rd[1]), 0);
    resetn = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 3) chk("lit_af_at3", 0, int'(o_af[0]), 0);
      if (i == 4) chk("lit_af_at4", 0, int'(o_af[0]), 1);
    end
    chk("lit_fill_cnt", 0, int'(o_cnt[0]), 5);
    chk("lit_fill_full", 0, int'(o_full[0]), 1);
    chk("lit_fill_head", 1, int'(o_rd[1]), 1);

    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("lit_ovf", 0, int'(o_ovf[0]), int'(ERR));
    chk("lit_ovf_cnt", 0, int'(o_cnt[0]), 5);

    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_drain_rd", 0, int'(o_rd[0]), (i <= 5) ? i : 5);
      if (i == 5) chk("lit_drain_empty", 0, int'(o_empty[0]), 1);
    end
    chk("lit_ovf_persist", 0, int'(o_ovf[0]), int'(ERR));
    chk("lit_unf", 0, int'(o_unf[0]), int'(ERR));

    cyc(1'b1, 8'h21, 1'b1, 1'b0);
    chk("lit_empty_both_cnt", 0, int'(o_cnt[0]), 1);
    chk("lit_empty_both_head", 1, int'(o_rd[1]), 8'h21);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lit_rd21", 0, int'(o_rd[0]), 8'h21);

    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    chk("lit_af4", 0, int'(o_af[0]), 1);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("lit_flush_cnt", 0, int'(o_cnt[0]), 0);
    chk("lit_flush_empty", 0, int'(o_empty[0]), 1);
    chk("lit_flush_ae", 0, int'(o_ae[0]), 1);
    chk("lit_flush_ovf", 0, int'(o_ovf[0]), 0);
    chk("lit_flush_unf", 0, int'(o_unf[0]), 0);
    chk("lit_flush_rd_hold", 0, int'(o_rd[0]), 8'h21);

    for (int i = 1; i <= 3; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_pre_wrap_rd", 0, int'(o_rd[0]), i);
    end
    for (int i = 10; i <= 14; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    chk("lit_wrap_full", 0, int'(o_full[0]), 1);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("lit_full_both_cnt", 0, int'(o_cnt[0]), 4);
    chk("lit_full_both_rd", 0, int'(o_rd[0]), 10);
    for (int j = 11; j <= 14; j++) begin
      chk("lit_wrap_head", 1, int'(o_rd[1]), j);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_wrap_rd", 0, int'(o_rd[0]), j);
    end
    chk("lit_aa_not_stored", 0, int'(o_empty[0]), 1);

    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("lit_fwft_3c", 1, int'(o_rd[1]), 8'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lit_fwft_empty", 1, int'(o_empty[1]), 1);
    chk("lit_fwft_zero", 1, int'(o_rd[1]), 0);

    cyc(1'b1, 8'h50, 1'b0, 1'b0);
    cyc(1'b1, 8'h51, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(8'h60 + i), 1'b1, 1'b0);
    chk("lit_stream_cnt", 0, int'(o_cnt[0]), 2);
    chk("lit_stream_rd", 0, int'(o_rd[0]), 8'h71);
    chk("lit_stream_head", 1, int'(o_rd[1]), 8'h72);

    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h83, 1'b0, 1'b0);
    chk("lit_ovf2", 0, int'(o_ovf[0]), int'(ERR));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    #2 resetn = 1'b0;
    #1;
    chk("lit_async_cnt", 0, int'(o_cnt[0]), 0);
    chk("lit_async_empty", 0, int'(o_empty[0]), 1);
    chk("lit_async_ovf", 0, int'(o_ovf[0]), 0);
    chk("lit_async_unf", 0, int'(o_unf[0]), 0);
    chk("lit_async_rd", 0, int'(o_rd[0]), 0);
    chk("lit_async_cnt", 1, int'(o_cnt[1]), 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lit_post_reset_rd", 0, int'(o_rd[0]), 8'h5A);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
